// File: rtl/csa_stream_accumulator.sv
// Streaming three-operand accumulator. Each accepted beat is folded into a
// registered carry-save pair (sum_q, carry_q), so the accumulate loop never
// propagates a carry. The last beat triggers one carry-propagate add, and the
// result is then held on a valid/ready output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACCUM   | accepting beats, folding each into sum_q/carry_q
// RESOLVE | single cycle: sum_q + carry_q -> out_sum, out_valid set
// HOLD    | result presented, waiting for out_ready
module csa_stream_accumulator #(
   parameter int WIDTH = 4,
   parameter int ACC_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] sum_q;
   logic [ACC_W-1:0] carry_q;
   logic             ovf_acc;
   logic [CNT_W-1:0] cnt;

   logic [ACC_W-1:0] a_ext, b_ext, c_ext;
   logic [ACC_W-1:0] s1, k1, k1_sh;
   logic [ACC_W-1:0] s2, k2, k2_sh;
   logic [ACC_W-1:0] s3, k3;
   logic             fold_ovf;
   logic [ACC_W:0]   resolve_sum;

   // in_ready depends only on state, so there is no path from in_valid
   assign in_ready = (state == ACCUM);

   // Three 3:2 compressor levels plus the one carry-propagate resolve add
   always_comb begin
      a_ext = {{(ACC_W-WIDTH){1'b0}}, in_a};
      b_ext = {{(ACC_W-WIDTH){1'b0}}, in_b};
      c_ext = {{(ACC_W-WIDTH){1'b0}}, in_c};

      s1    = a_ext ^ b_ext ^ c_ext;
      k1    = (a_ext & b_ext) | (a_ext & c_ext) | (b_ext & c_ext);
      k1_sh = {k1[ACC_W-2:0], 1'b0};

      s2    = s1 ^ k1_sh ^ sum_q;
      k2    = (s1 & k1_sh) | (s1 & sum_q) | (k1_sh & sum_q);
      k2_sh = {k2[ACC_W-2:0], 1'b0};

      s3    = s2 ^ k2_sh ^ carry_q;
      k3    = (s2 & k2_sh) | (s2 & carry_q) | (k2_sh & carry_q);

      // A carry pushed out of the MSB is a lost 2^ACC_W, so it is sticky overflow
      fold_ovf = k1[ACC_W-1] | k2[ACC_W-1] | k3[ACC_W-1];

      resolve_sum = {1'b0, sum_q} + {1'b0, carry_q};
   end

   // Sequencer, carry-save accumulator and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         sum_q     <= '0;
         carry_q   <= '0;
         ovf_acc   <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         out_count <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  sum_q   <= s3;
                  carry_q <= {k3[ACC_W-2:0], 1'b0};
                  ovf_acc <= ovf_acc | fold_ovf;
                  if (cnt != {CNT_W{1'b1}})
                     cnt <= cnt + CNT_W'(1);
                  if (in_last)
                     state <= RESOLVE;
               end
            end
            RESOLVE: begin
               out_sum   <= resolve_sum[ACC_W-1:0];
               out_ovf   <= ovf_acc | resolve_sum[ACC_W];
               out_count <= cnt;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  sum_q     <= '0;
                  carry_q   <= '0;
                  ovf_acc   <= 1'b0;
                  cnt       <= '0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: directed cases with literal expectations
// plus randomized streams, all checked each cycle against a true-sum model.
module tb_csa_stream_accumulator;

   localparam int WIDTH = 4;
   localparam int ACC_W = 8;
   localparam int CNT_W = 8;
   localparam longint MOD = longint'(1) << ACC_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0, in_b = '0, in_c = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   int total = 0;
   int bad = 0;
   bit rnd_mode = 1'b0;
   bit dir_ready = 1'b0;

   csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // out_ready source: random during regression, directed otherwise
   always @(posedge clk) begin
      #2;
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : dir_ready;
   end

   // Reference model: true running sum and beat count; one pending result at most
   longint run_sum = 0;
   int     run_cnt = 0;
   bit     pend = 1'b0;
   int     age = 0;
   longint exp_sum = 0;
   int     exp_cnt = 0;
   longint h_sum = 0;
   longint h_ovf = 0;
   longint h_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         run_sum = 0; run_cnt = 0; pend = 1'b0; age = 0;
         h_sum = 0; h_ovf = 0; h_cnt = 0;
      end else begin
         chk("in_ready", in_ready, !pend);
         if (pend) age++;
         chk("out_valid", out_valid, pend && age >= 2);
         if (out_valid) begin
            chk("m_sum", out_sum, exp_sum % MOD);
            chk("m_ovf", out_ovf, exp_sum >= MOD);
            chk("m_count", out_count, (exp_cnt > CNT_MAX) ? CNT_MAX : exp_cnt);
            if (out_ready && pend) begin
               pend = 1'b0;
               h_sum = exp_sum % MOD;
               h_ovf = (exp_sum >= MOD);
               h_cnt = (exp_cnt > CNT_MAX) ? CNT_MAX : exp_cnt;
            end
         end else begin
            chk("held_sum", out_sum, h_sum);
            chk("held_ovf", out_ovf, h_ovf);
            chk("held_count", out_count, h_cnt);
         end
         if (in_valid && in_ready) begin
            run_sum += longint'(in_a) + longint'(in_b) + longint'(in_c);
            run_cnt++;
            if (in_last) begin
               exp_sum = run_sum; exp_cnt = run_cnt;
               pend = 1'b1; age = 0;
               run_sum = 0; run_cnt = 0;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int a, input int b, input int c, input bit last);
      int n = 0;
      while (!in_ready) begin
         @(posedge clk); #1;
         n++;
         if (n > 1000) begin
            chk("send_timeout", 0, 1);
            return;
         end
      end
      in_valid = 1'b1;
      in_a = WIDTH'(a); in_b = WIDTH'(b); in_c = WIDTH'(c);
      in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic get_result(input int es, input int eo, input int ec, input string nm);
      int n = 0;
      dir_ready = 1'b1;
      while (!out_valid) begin
         @(posedge clk); #1;
         n++;
         if (n > 50) begin
            chk({nm, "_timeout"}, 0, 1);
            dir_ready = 1'b0;
            return;
         end
      end
      chk({nm, "_sum"}, out_sum, es);
      chk({nm, "_ovf"}, out_ovf, eo);
      chk({nm, "_count"}, out_count, ec);
      @(posedge clk); #1;
      dir_ready = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // single beat, latency check
      send(15, 15, 15, 1'b1);
      chk("lat_edge_k", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_edge_k1", out_valid, 1);
      get_result(45, 0, 1, "single");

      // six back-to-back beats with overflow
      for (int i = 0; i < 6; i++) begin
         chk("six_ready", in_ready, 1);
         send(15, 15, 15, i == 5);
      end
      get_result(14, 1, 6, "six");

      // mixed beats then a zero beat confirming the clear
      send(1, 2, 3, 1'b0);
      send(4, 5, 6, 1'b0);
      send(7, 8, 9, 1'b1);
      get_result(45, 0, 3, "three");
      send(0, 0, 0, 1'b1);
      get_result(0, 0, 1, "zero");

      // backpressure in HOLD with in_valid asserted
      send(10, 11, 12, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_c = WIDTH'($urandom);
         in_last = 1'($urandom_range(0, 1));
         chk("bp_in_ready", in_ready, 0);
         chk("bp_sum", out_sum, 33);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      get_result(33, 0, 1, "bp");
      send(2, 3, 4, 1'b1);
      get_result(9, 0, 1, "after_bp");

      // asynchronous reset mid-stream
      send(15, 15, 15, 1'b0);
      send(15, 15, 15, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_sum", out_sum, 0);
      chk("arst_out_count", out_count, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send(1, 1, 1, 1'b1);
      get_result(3, 0, 1, "post_rst");

      // beat-count saturation: 300 beats of (1,1,1) -> 900
      for (int i = 0; i < 300; i++) send(1, 1, 1, i == 299);
      get_result(900 % 256, 1, 255, "sat");

      // randomized streams with random gaps and random out_ready
      rnd_mode = 1'b1;
      for (int s = 0; s < 2000; s++) begin
         int len;
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            int gap;
            gap = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
            repeat (gap) begin @(posedge clk); #1; end
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), i == len - 1);
         end
      end
      begin
         int n = 0;
         while (pend && n < 500) begin @(posedge clk); #1; n++; end
         if (pend) chk("drain_timeout", 0, 1);
      end
      rnd_mode = 1'b0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
